sdp_erdma_eg_ro_dfifo_ctrl: RTL and testbench

Depth-2 valid/ready data FIFO for the SDP ERDMA egress read-out path. It sequences one 1x256 flop-RAM entry, generating its write enable and its bypass select, and adds a registered output stage. Data arriving at an empty FIFO falls through to the output register in one cycle. It sits between the ERDMA return-data unpacker (write side) and the egress read-out consumer (read side).

---
 rtl/sdp_erdma_eg_ro_dfifo_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sdp_erdma_eg_ro_dfifo_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_erdma_eg_ro_dfifo_ctrl.sv
// -----------------------------------------------------------------------------
// sdp_erdma_eg_ro_dfifo_ctrl
//
// Depth-2 valid/ready data FIFO on the SDP ERDMA egress read-out path.
// Storage is one flop-RAM entry plus a registered output stage. A beat that
// arrives while the output stage can take it falls straight through to the
// output register, so an empty FIFO has one cycle of latency and the RAM is
// written only when the output stage is occupied and stalled.
//
// Handshake: a beat transfers on a side exactly in a cycle where that side's
// valid and ready are both 1 at the rising clock edge. Valid, once raised,
// holds with stable payload until the transfer. Ready may be used to qualify
// payload only together with valid.
//
// Ports
//   i_clk            core clock, all state on the rising edge
//   i_rst            asynchronous active-high reset
//   i_wr_pvld        write-side valid
//   o_wr_prdy        write-side ready (combinational: RAM entry is free)
//   i_wr_pd          write payload (DW bits)
//   o_rd_pvld        read-side valid (registered)
//   i_rd_prdy        read-side ready
//   o_rd_pd          read payload (registered)
//   o_fifo_count     occupancy 0..2 (registered)
//   o_fifo_idle      1 when occupancy is 0 (registered)
//   i_pwrbus_ram_pd  RAM power-control bus, passed to the flop-RAM
// -----------------------------------------------------------------------------
module sdp_erdma_eg_ro_dfifo_ctrl #(
  parameter int DW = 256
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_pvld,
  output logic          o_wr_prdy,
  input  logic [DW-1:0] i_wr_pd,
  output logic          o_rd_pvld,
  input  logic          i_rd_prdy,
  output logic [DW-1:0] o_rd_pd,
  output logic [1:0]    o_fifo_count,
  output logic          o_fifo_idle,
  input  logic [31:0]   i_pwrbus_ram_pd
);

  logic          r_ram_valid;
  logic          r_rd_pvld;
  logic [DW-1:0] r_rd_pd;
  logic [1:0]    r_fifo_count;
  logic          r_fifo_idle;

  logic          w_wr_prdy;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_out_load;
  logic          w_ram_we;
  logic          w_ram_ra;
  logic [DW-1:0] w_ram_dout;
  logic [1:0]    w_count_nxt;

  assign w_wr_prdy = !r_ram_valid;
  assign w_wr_acc  = i_wr_pvld & w_wr_prdy;
  assign w_rd_acc  = r_rd_pvld & i_rd_prdy;

  // The output register takes a new beat whenever it is empty or being read,
  // and there is something to give it: the stored entry first, else the
  // incoming write.
  assign w_out_load = (!r_rd_pvld | i_rd_prdy) & (r_ram_valid | w_wr_acc);

  // ra=0 reads the stored entry, ra=1 passes di straight through.
  assign w_ram_ra = !r_ram_valid;

  // Only a write that cannot fall through is stored.
  assign w_ram_we = w_wr_acc & !w_out_load;

  sdp_erdma_eg_ro_dfifo_flopram_1x256 #(
    .DW (DW)
  ) u_ram (
    .i_clk           (i_clk),
    .i_pwrbus_ram_pd (i_pwrbus_ram_pd),
    .i_di            (i_wr_pd),
    .i_we            (w_ram_we),
    .i_ra            (w_ram_ra),
    .o_dout          (w_ram_dout)
  );

  // Occupancy can only go 0..2: a write is refused while the RAM entry is
  // full, and a read needs rd_pvld, which implies a non-zero count.
  assign w_count_nxt = r_fifo_count + {1'b0, w_wr_acc} - {1'b0, w_rd_acc};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ram_valid  <= 1'b0;
      r_rd_pvld    <= 1'b0;
      r_rd_pd      <= '0;
      r_fifo_count <= 2'd0;
      r_fifo_idle  <= 1'b1;
    end else begin
      if (r_ram_valid && w_out_load) begin
        r_ram_valid <= 1'b0;
      end else if (!r_ram_valid && w_ram_we) begin
        r_ram_valid <= 1'b1;
      end

      if (w_out_load) begin
        r_rd_pvld <= 1'b1;
        r_rd_pd   <= w_ram_dout;
      end else if (w_rd_acc) begin
        r_rd_pvld <= 1'b0;
      end

      r_fifo_count <= w_count_nxt;
      r_fifo_idle  <= (w_count_nxt == 2'd0);
    end
  end

  assign o_wr_prdy    = w_wr_prdy;
  assign o_rd_pvld    = r_rd_pvld;
  assign o_rd_pd      = r_rd_pd;
  assign o_fifo_count = r_fifo_count;
  assign o_fifo_idle  = r_fifo_idle;

endmodule

// -----------------------------------------------------------------------------
// sdp_erdma_eg_ro_dfifo_flopram_1x256
//
// One-entry flop RAM with write-through read select. Contents are not reset.
//
// Ports
//   i_clk            clock
//   i_pwrbus_ram_pd  power-control bus (no effect on a flop array)
//   i_di             write data
//   i_we             write enable
//   i_ra             read address: 0 = stored entry, 1 = i_di bypass
//   o_dout           read data
// -----------------------------------------------------------------------------
module sdp_erdma_eg_ro_dfifo_flopram_1x256 #(
  parameter int DW = 256
) (
  input  logic          i_clk,
  input  logic [31:0]   i_pwrbus_ram_pd,
  input  logic [DW-1:0] i_di,
  input  logic          i_we,
  input  logic          i_ra,
  output logic [DW-1:0] o_dout
);

  logic [DW-1:0] r_mem;
  logic          w_unused_pwrbus;

  assign w_unused_pwrbus = ^i_pwrbus_ram_pd;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem <= i_di;
    end
  end

  assign o_dout = i_ra ? i_di : r_mem;

endmodule

// File: tb/tb_sdp_erdma_eg_ro_dfifo_ctrl.sv
// -----------------------------------------------------------------------------
// Directed bench for sdp_erdma_eg_ro_dfifo_ctrl. Inputs change 1 time unit
// after the rising edge; outputs are checked 1 unit after that, so registered
// outputs reflect the previous edge and combinational ones the current inputs.
// -----------------------------------------------------------------------------
module tb_sdp_erdma_eg_ro_dfifo_ctrl;

  localparam int DW = 256;

  logic          clk;
  logic          rst;
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic [1:0]    fifo_count;
  logic          fifo_idle;
  logic [31:0]   pwrbus_ram_pd;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];

  sdp_erdma_eg_ro_dfifo_ctrl #(
    .DW (DW)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_wr_pvld       (wr_pvld),
    .o_wr_prdy       (wr_prdy),
    .i_wr_pd         (wr_pd),
    .o_rd_pvld       (rd_pvld),
    .i_rd_prdy       (rd_prdy),
    .o_rd_pd         (rd_pd),
    .o_fifo_count    (fifo_count),
    .o_fifo_idle     (fifo_idle),
    .i_pwrbus_ram_pd (pwrbus_ram_pd)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  localparam logic [DW-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [DW-1:0] PAT_5A = {32{8'h5A}};

  initial begin
    logic [DW-1:0] next_beat;
    int            sent;
    int            cyc;
    logic          w_acc;
    logic          r_acc;

    rst           = 1'b1;
    wr_pvld       = 1'b0;
    rd_prdy       = 1'b0;
    wr_pd         = '0;
    pwrbus_ram_pd = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // reset then idle
    settle();
    chk("rst_rd_pvld", rd_pvld, 0);
    chk("rst_rd_pd", rd_pd, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_idle", fifo_idle, 1);
    chk("rst_wr_prdy", wr_prdy, 1);
    chk("rst_ram_valid", dut.r_ram_valid, 0);

    // single fall-through write with reader ready
    tick();
    wr_pvld = 1'b1; wr_pd = PAT_A5; rd_prdy = 1'b1;
    settle();
    chk("ft_we0", dut.w_ram_we, 0);
    tick();
    wr_pvld = 1'b0; wr_pd = 'x;
    settle();
    chk("ft_rd_pvld", rd_pvld, 1);
    chk("ft_rd_pd", rd_pd, PAT_A5);
    chk("ft_count1", fifo_count, 1);
    chk("ft_idle0", fifo_idle, 0);
    chk("ft_we1", dut.w_ram_we, 0);
    tick();
    settle();
    chk("ft_rd_pvld_clr", rd_pvld, 0);
    chk("ft_count0", fifo_count, 0);
    chk("ft_idle1", fifo_idle, 1);
    chk("ft_rd_pd_hold", rd_pd, PAT_A5);

    // fill with reader stalled: beat1 to output, beat2 to RAM, beat3 refused
    rd_prdy = 1'b0; wr_pvld = 1'b1; wr_pd = 1;
    settle();
    chk("fill_prdy_b1", wr_prdy, 1);
    chk("fill_we_b1", dut.w_ram_we, 0);
    tick();
    wr_pd = 2;
    settle();
    chk("fill_rd_pd_b1", rd_pd, 1);
    chk("fill_count1", fifo_count, 1);
    chk("fill_prdy_b2", wr_prdy, 1);
    chk("fill_we_b2", dut.w_ram_we, 1);
    tick();
    wr_pd = 3;
    settle();
    chk("full_count", fifo_count, 2);
    chk("full_prdy", wr_prdy, 0);
    chk("full_ram_valid", dut.r_ram_valid, 1);
    chk("full_we_b3", dut.w_ram_we, 0);
    tick();
    settle();
    chk("full_count_hold", fifo_count, 2);
    chk("full_rd_pd_stable", rd_pd, 1);

    // drain from full while beat3 waits: order 1,2,3 and one-cycle bubble
    rd_prdy = 1'b1;
    settle();
    chk("drn_count_a", fifo_count, 2);
    chk("drn_prdy_a", wr_prdy, 0);
    chk("drn_rd_pd_a", rd_pd, 1);
    tick();
    settle();
    chk("drn_count_b", fifo_count, 1);
    chk("drn_prdy_b", wr_prdy, 1);
    chk("drn_rd_pd_b", rd_pd, 2);
    chk("drn_we_b", dut.w_ram_we, 0);
    tick();
    wr_pvld = 1'b0;
    settle();
    chk("drn_count_c", fifo_count, 1);
    chk("drn_rd_pd_c", rd_pd, 3);
    tick();
    rd_prdy = 1'b0;
    settle();
    chk("drn_count_d", fifo_count, 0);
    chk("drn_rd_pvld_d", rd_pvld, 0);

    // random stream of 64 incrementing beats against a queue scoreboard
    exp_q.delete();
    next_beat = 256'h100;
    sent = 0;
    cyc = 0;
    while ((sent < 64 || exp_q.size() != 0) && cyc < 3000) begin
      wr_pvld = (sent < 64) ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_pd   = wr_pvld ? next_beat : {8{$urandom()}};
      rd_prdy = 1'($urandom_range(0, 1));
      settle();
      chk("str_count", fifo_count, exp_q.size());
      chk("str_rd_pvld", rd_pvld, (exp_q.size() != 0));
      chk("str_wr_prdy", wr_prdy, (exp_q.size() != 2));
      if (rd_pvld && exp_q.size() != 0) chk("str_rd_pd", rd_pd, exp_q[0]);
      w_acc = wr_pvld & wr_prdy;
      r_acc = rd_pvld & rd_prdy;
      if (r_acc && exp_q.size() != 0) void'(exp_q.pop_front());
      if (w_acc) begin
        exp_q.push_back(next_beat);
        next_beat = next_beat + 1;
        sent++;
      end
      tick();
      cyc++;
    end
    total++;
    if (cyc >= 3000) begin
      bad++;
      $error("FAIL str_budget observed=%0d cycles expected=<3000 sent=%0d", cyc, sent);
    end
    wr_pvld = 1'b0; rd_prdy = 1'b0;
    settle();
    chk("str_end_count", fifo_count, 0);
    chk("str_end_idle", fifo_idle, 1);

    // reset while full, then a clean fall-through
    tick();
    wr_pvld = 1'b1; wr_pd = 256'h11;
    tick();
    wr_pd = 256'h22;
    tick();
    wr_pvld = 1'b0;
    settle();
    chk("pre_rst_count", fifo_count, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_pvld", rd_pvld, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_idle", fifo_idle, 1);
    chk("mid_rst_prdy", wr_prdy, 1);
    chk("mid_rst_rd_pd", rd_pd, 0);
    tick();
    rst = 1'b0;
    tick();
    wr_pvld = 1'b1; wr_pd = PAT_5A;
    tick();
    wr_pvld = 1'b0; wr_pd = 'x;
    settle();
    chk("post_rst_rd_pvld", rd_pvld, 1);
    chk("post_rst_rd_pd", rd_pd, PAT_5A);
    chk("post_rst_count", fifo_count, 1);
    chk("post_rst_ram_valid", dut.r_ram_valid, 0);
    tick();
    settle();
    chk("post_rst_stable", rd_pd, PAT_5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
